// File: rtl/imem_load_ctrl.sv
// Debug program loader: streams host words into IMEM over DEBUG_* and then releases the core through START.
// Latency: each write strobe appears 1 cycle after its beat is accepted; START rises 2 cycles after the last accept.
// Backpressure: in_ready depends only on state (high only in LOAD); the host holds its word while in_ready is low.
module imem_load_ctrl #(
    parameter int LEN_W   = 10,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load_req,
    input  logic [LEN_W-1:0] load_len,
    input  logic [31:0]      base_addr,
    input  logic             halt_req,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             DEBUG_SIG,
    output logic             DEBUG_we,
    output logic [31:0]      DEBUG_addr,
    output logic [31:0]      DEBUG_instr,
    output logic             START,
    output logic             busy,
    output logic             err,
    output logic [LEN_W-1:0] words_loaded
);

    // The idle counter never needs to hold more than TIMEOUT-1.
    localparam int TO_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [LEN_W-1:0]  len_q;
    logic [31:0]       base_q;
    logic [TO_W-1:0]   to_cnt_q;

    logic              beat;
    logic              last_beat;
    logic              start_load;
    logic              req_reject;
    logic              to_expire;

    // The outputs below are decoded from state alone, so in_ready never depends on in_valid.
    assign in_ready  = (state_q == S_LOAD);
    assign DEBUG_SIG = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign busy      = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign START     = (state_q == S_RUN);

    // Update the state register. Reset returns to IDLE at once, which also drops START and DEBUG_SIG.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the single-cycle control events that drive the datapath.
    always_comb begin
        state_d    = state_q;
        start_load = 1'b0;
        req_reject = 1'b0;
        to_expire  = 1'b0;
        beat       = (state_q == S_LOAD) && in_valid;
        last_beat  = beat && (words_loaded == (len_q - LEN_W'(1)));
        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    if (load_len != '0) begin
                        start_load = 1'b1;
                        state_d    = S_LOAD;
                    end else begin
                        req_reject = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // In LOAD and DRAIN, load_req and halt_req are ignored on purpose.
                if (last_beat) begin
                    state_d = S_DRAIN;
                end else if (!in_valid && (to_cnt_q == TO_W'(TIMEOUT - 1))) begin
                    to_expire = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Stay here one cycle so the final write strobe lands while the core is still held.
                state_d = S_RUN;
            end
            S_RUN: begin
                // When load_req and halt_req arrive together, load_req takes priority.
                if (load_req) begin
                    if (load_len != '0) begin
                        start_load = 1'b1;
                        state_d    = S_LOAD;
                    end else begin
                        req_reject = 1'b1;
                    end
                end else if (halt_req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Latch the request parameters and advance the word and idle counters.
    // After a timeout, words_loaded keeps the partial count.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            len_q        <= '0;
            base_q       <= '0;
            words_loaded <= '0;
            to_cnt_q     <= '0;
        end else if (start_load) begin
            len_q        <= load_len;
            base_q       <= base_addr;
            words_loaded <= '0;
            to_cnt_q     <= '0;
        end else if (beat) begin
            words_loaded <= words_loaded + LEN_W'(1);
            to_cnt_q     <= '0;
        end else if (state_q == S_LOAD) begin
            to_cnt_q     <= to_cnt_q + TO_W'(1);
        end
    end

    // Register the IMEM write port. Address and data keep their last values between strobes.
    // The address wraps silently modulo 2^32.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            DEBUG_we    <= 1'b0;
            DEBUG_addr  <= '0;
            DEBUG_instr <= '0;
        end else begin
            DEBUG_we <= beat;
            if (beat) begin
                DEBUG_addr  <= base_q + 32'(words_loaded);
                DEBUG_instr <= in_data;
            end
        end
    end

    // Generate the error pulse. A single rejected request or timeout yields exactly one cycle of err.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err <= 1'b0;
        end else begin
            err <= req_reject | to_expire;
        end
    end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Sequencer that owns the core's debug program-load path into instruction memory. Accepts 32-bit instruction words from a host stream (valid/ready), writes them to consecutive IMEM word addresses on the DEBUG_* write port, then releases the core with START. Supports halt-and-reload, a stall timeout and error reporting. Sits between the host/UART front end and the core's DEBUG_SIG/DEBUG_addr/DEBUG_instr/START inputs.

## Interface
- LEN_W, 10, width of word count and word index (max program 2^LEN_W − 1 words)
- TIMEOUT, 1024, idle cycles with no in_valid in LOAD before abort (≥2)

- clk  in  1  clock, all state on rising edge
- nrst  in  1  reset, asynchronous and active-low
- load_req  in  1  start a load; sampled in IDLE and RUN, ignored elsewhere
- load_len  in  LEN_W  words to load; sampled with load_req
- base_addr  in  32  IMEM word address of first word; sampled with load_req
- halt_req  in  1  in RUN: drop START, return to IDLE
- in_valid  in  1  host word valid
- in_data  in  32  host instruction word
- in_ready  out  1  high exactly when state is LOAD (Moore, no dependence on in_valid)
- DEBUG_SIG  out  1  debug owns IMEM write port, core held
- DEBUG_we  out  1  one-cycle IMEM write strobe
- DEBUG_addr  out  32  IMEM word address
- DEBUG_instr  out  32  IMEM write data
- START  out  1  core run enable, level
- busy  out  1  state is LOAD or DRAIN
- err  out  1  one-cycle pulse on rejected request or timeout
- words_loaded  out  LEN_W  words written in the current/last load

## Operation
- States: IDLE, LOAD, DRAIN, RUN.
- Reset (async, nrst low): state IDLE; DEBUG_SIG=0, DEBUG_we=0, DEBUG_addr=0, DEBUG_instr=0, START=0, err=0, words_loaded=0; internal word counter and timeout counter 0.
- IDLE: START=0, DEBUG_SIG=0. load_req with load_len≠0 → LOAD; latch load_len and base_addr, clear words_loaded and both counters. load_req with load_len=0 → err pulse, stay IDLE.
- LOAD: DEBUG_SIG=1, in_ready=1. Each beat (in_valid & in_ready): next cycle DEBUG_we=1, DEBUG_addr=base_addr+index, DEBUG_instr=in_data; index and words_loaded increment; timeout counter clears. Accepting beat number load_len → DRAIN. Timeout counter increments on every LOAD cycle without in_valid; reaching TIMEOUT → IDLE with err pulse, DEBUG_SIG drops, words_loaded keeps the partial count.
- DRAIN: one cycle; DEBUG_SIG=1, in_ready=0, final write strobe visible. → RUN.
- RUN: START=1, DEBUG_SIG=0. halt_req → IDLE (START=0 next cycle). load_req with load_len≠0 → LOAD (START=0 next cycle, same as IDLE entry); load_len=0 → err pulse, remain RUN. load_req and halt_req together: load_req wins.
- load_req/halt_req in LOAD or DRAIN: ignored, no err.
- Address arithmetic: 32-bit modulo 2^32; base_addr+index wraps silently at 0xFFFFFFFF.
- DEBUG_addr/DEBUG_instr hold last written values when DEBUG_we=0.

## Timing
- in_ready is combinational from state only; a beat is accepted in the cycle it is presented with in_ready high.
- Beat accepted at edge t → DEBUG_we/addr/instr valid during cycle t+1 (1-cycle latency); back-to-back beats give back-to-back writes, one per cycle.
- Last beat at edge t → state DRAIN in t+1 (last write strobe), RUN in t+2: START rises 2 cycles after last accept.
- load_req at edge t in IDLE → in_ready high in cycle t+1.
- Timeout: TIMEOUT consecutive no-valid cycles in LOAD → err high and state IDLE in the following cycle; any accepted beat restarts the count.
- nrst asserted mid-load: immediate return to reset values; no further writes; START stays 0 until a complete new load.
- err is never high for two consecutive cycles from a single event.

## Test plan
- Reset then load_req, load_len=3, base_addr=0x10, words 0xA,0xB,0xC back-to-back → writes (0x10,0xA),(0x11,0xB),(0x12,0xC) on consecutive cycles, START=1 two cycles after third accept, words_loaded=3.
- Same load with in_valid gapped (1 on, 2 off) → identical write sequence, in_ready held high throughout, no err.
- load_len=0 in IDLE and in RUN → single-cycle err, state unchanged, no DEBUG_we.
- TIMEOUT=8, load_len=4, send 2 words then stall 8 cycles → err pulse, DEBUG_SIG=0, START=0, words_loaded=2; subsequent full load succeeds.
- In RUN: halt_req → START=0 next cycle; then load_req+halt_req same cycle in RUN → LOAD entered, reload of 2 words at base 0x0 → START returns.
- base_addr=0xFFFFFFFF, load_len=2 → addresses 0xFFFFFFFF then 0x00000000; nrst pulse mid-load → all outputs at reset values, no further DEBUG_we.
